// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port negedge data RAM
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    // cmd_valid expressed as a two-state machine: ISSUE means a command sits on the RAM port
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t              state_q;
    logic                last_q;        // last-served port; 1 after reset so port 0 wins first
    logic                cmd_port_q;    // port the in-flight command belongs to
    logic                rd_pending_q;  // in-flight command is a read
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                p0_rvalid_q;
    logic                p1_rvalid_q;
    logic [DATA_W-1:0]   p0_rdata_q;
    logic [DATA_W-1:0]   p1_rdata_q;

    logic                gnt0_d;
    logic                gnt1_d;
    logic                accept_d;
    logic                sel_port_d;
    logic                sel_we_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;
    logic                rsp_p0_d;
    logic                rsp_p1_d;

    // Byte-offset and out-of-range address bits never reach the RAM (addresses wrap)
    logic                addr_unused;
    assign addr_unused = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0],
                           p1_addr[31:ADDR_W+2], p1_addr[1:0]};

    // Grant decision: single requester wins outright, conflicts go by priority mode
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (rst_n) begin
            if (p0_req && p1_req) begin
                if ((FIXED_PRIO != 0) || last_q) begin
                    gnt0_d = 1'b1;
                end else begin
                    gnt1_d = 1'b1;
                end
            end else begin
                gnt0_d = p0_req;
                gnt1_d = p1_req;
            end
        end
    end

    // Mux the winning command and decode which port the RAM result belongs to
    always_comb begin
        accept_d    = gnt0_d | gnt1_d;
        sel_port_d  = gnt1_d;
        sel_we_d    = gnt1_d ? p1_we : p0_we;
        sel_addr_d  = gnt1_d ? p1_addr[ADDR_W+1:2] : p0_addr[ADDR_W+1:2];
        sel_wdata_d = gnt1_d ? p1_wdata : p0_wdata;
        rsp_p0_d    = (state_q == ST_ISSUE) && rd_pending_q && !cmd_port_q;
        rsp_p1_d    = (state_q == ST_ISSUE) && rd_pending_q &&  cmd_port_q;
    end

    // Command register, state machine and response capture; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            cmd_port_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            p0_rvalid_q <= rsp_p0_d;
            p1_rvalid_q <= rsp_p1_d;
            if (rsp_p0_d) begin
                p0_rdata_q <= mem_dout;
            end
            if (rsp_p1_d) begin
                p1_rdata_q <= mem_dout;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!accept_d) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept_d) begin
                last_q       <= sel_port_d;
                cmd_port_q   <= sel_port_d;
                rd_pending_q <= !sel_we_d;
                mem_we_q     <= sel_we_d;
                mem_addr_q   <= sel_addr_d;
                mem_din_q    <= sel_wdata_d;
            end else begin
                rd_pending_q <= 1'b0;
                mem_we_q     <= 1'b0;
            end
        end
    end

    assign p0_gnt    = gnt0_d;
    assign p1_gnt    = gnt1_d;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table, corner sequences and random model check
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        ram_reload = 1'b0;

    logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_mem_we;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_din, a_mem_dout;
    logic [9:0]  a_mem_addr;
    logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid, b_mem_we;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_din, b_mem_dout;
    logic [9:0]  b_mem_addr;

    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    function automatic logic [31:0] preload(input int i);
        return 32'hA000_0000 + i;
    endfunction

    // Negedge single-port RAMs, one per DUT
    always @(negedge clk) begin
        if (ram_reload) begin
            for (int i = 0; i < 1024; i++) begin
                ram_a[i] = preload(i);
                ram_b[i] = preload(i);
            end
        end else begin
            if (a_mem_we) ram_a[a_mem_addr] = a_mem_din;
            if (b_mem_we) ram_b[b_mem_addr] = b_mem_din;
            a_mem_dout <= ram_a[a_mem_addr];
            b_mem_dout <= ram_b[b_mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        rst_n = rst;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic reset_all();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        ram_reload = 1'b1;
        tick();
        tick();
        ram_reload = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  gnt;    // {p1,p0}
        logic        mwe;
        logic [9:0]  maddr;  // checked only when mwe
        logic [1:0]  rv;     // {p1,p0}
        logic [31:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic r1, input logic w1,
                                input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] g,
                                input logic mwe, input logic [9:0] ma, input logic [1:0] rv,
                                input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.gnt = g; v.mwe = mwe; v.maddr = ma; v.rv = rv; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    vec_t        tbl [20];
    logic [31:0] mdl_mem [1024];
    rsp_t        q [$];

    initial begin
        int          n0, n1, n;
        logic        rr, r0, r1, w0, w1, eg0, eg1, ev0, ev1, last;
        logic        pv_acc, pv_we;
        logic [9:0]  pv_addr;
        logic [31:0] a0, a1, d0, d1, pv_din, erd0, erd1;
        logic        o_g0, o_g1, o_we, o_rv0, o_rv1;
        logic [9:0]  o_addr;
        logic [31:0] o_din, o_rd0, o_rd1;

        tbl[0]  = mk(0, 1,0,32'h10,0,          1,0,32'h20,0, 2'b00, 0,  0, 2'b00, 0, 0);
        tbl[1]  = mk(0, 1,0,32'h10,0,          1,0,32'h20,0, 2'b00, 0,  0, 2'b00, 0, 0);
        tbl[2]  = mk(1, 1,0,32'h10,0,          1,0,32'h20,0, 2'b01, 0,  0, 2'b00, 0, 0);
        tbl[3]  = mk(1, 1,1,32'h10,32'hDEADBEEF, 1,0,32'h20,0, 2'b10, 0,  0, 2'b00, 0, 0);
        tbl[4]  = mk(1, 1,1,32'h10,32'hDEADBEEF, 1,0,32'h24,0, 2'b01, 0,  0, 2'b01, 32'hA0000004, 0);
        tbl[5]  = mk(1, 1,0,32'h10,0,          0,0,0,0,      2'b01, 1,  4, 2'b10, 32'hA0000004, 32'hA0000008);
        tbl[6]  = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 32'hA0000004, 32'hA0000008);
        tbl[7]  = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b01, 32'hDEADBEEF, 32'hA0000008);
        tbl[8]  = mk(1, 0,0,0,0,               1,1,32'h20,32'h0000CAFE, 2'b10, 0, 0, 2'b00, 32'hDEADBEEF, 32'hA0000008);
        tbl[9]  = mk(1, 1,0,32'h20,0,          0,0,0,0,      2'b01, 1,  8, 2'b00, 32'hDEADBEEF, 32'hA0000008);
        tbl[10] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 32'hDEADBEEF, 32'hA0000008);
        tbl[11] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b01, 32'h0000CAFE, 32'hA0000008);
        tbl[12] = mk(1, 1,0,32'hFFFFF010,0,    0,0,0,0,      2'b01, 0,  0, 2'b00, 32'h0000CAFE, 32'hA0000008);
        tbl[13] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 32'h0000CAFE, 32'hA0000008);
        tbl[14] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b01, 32'hDEADBEEF, 32'hA0000008);
        tbl[15] = mk(1, 1,0,32'h24,0,          0,0,0,0,      2'b01, 0,  0, 2'b00, 32'hDEADBEEF, 32'hA0000008);
        tbl[16] = mk(0, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 32'hDEADBEEF, 32'hA0000008);
        tbl[17] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 0, 0);
        tbl[18] = mk(1, 0,0,0,0,               0,0,0,0,      2'b00, 0,  0, 2'b00, 0, 0);
        tbl[19] = mk(1, 1,0,32'h10,0,          1,0,32'h20,0, 2'b01, 0,  0, 2'b00, 0, 0);

        reset_all();

        // Directed table on the round-robin instance
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d gnt", i), {30'd0, a_p1_gnt, a_p0_gnt}, {30'd0, tbl[i].gnt});
            chk($sformatf("tbl%0d mem_we", i), {31'd0, a_mem_we}, {31'd0, tbl[i].mwe});
            if (tbl[i].mwe)
                chk($sformatf("tbl%0d mem_addr", i), {22'd0, a_mem_addr}, {22'd0, tbl[i].maddr});
            chk($sformatf("tbl%0d rvalid", i), {30'd0, a_p1_rvalid, a_p0_rvalid}, {30'd0, tbl[i].rv});
            chk($sformatf("tbl%0d p0_rdata", i), a_p0_rdata, tbl[i].rd0);
            chk($sformatf("tbl%0d p1_rdata", i), a_p1_rdata, tbl[i].rd1);
            tick();
        end

        // Round-robin alternation with continuous reads from both ports
        reset_all();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 10; c++) begin
            rr = (c < 8);
            drive(1'b1, rr, 1'b0, (16 + n0) * 4, 0, rr, 1'b0, (32 + n1) * 4, 0);
            #1;
            chk($sformatf("rr%0d p0_gnt", c), {31'd0, a_p0_gnt}, {31'd0, rr && (c % 2 == 0)});
            chk($sformatf("rr%0d p1_gnt", c), {31'd0, a_p1_gnt}, {31'd0, rr && (c % 2 == 1)});
            ev0 = (c >= 2) && ((c - 2) % 2 == 0);
            ev1 = (c >= 3) && ((c - 2) % 2 == 1);
            n = (c - 2) >>> 1;
            chk($sformatf("rr%0d p0_rvalid", c), {31'd0, a_p0_rvalid}, {31'd0, ev0});
            chk($sformatf("rr%0d p1_rvalid", c), {31'd0, a_p1_rvalid}, {31'd0, ev1});
            if (ev0) chk($sformatf("rr%0d p0_rdata", c), a_p0_rdata, preload(16 + n));
            if (ev1) chk($sformatf("rr%0d p1_rdata", c), a_p1_rdata, preload(32 + n));
            if (rr && (c % 2 == 0)) n0++;
            if (rr && (c % 2 == 1)) n1++;
            tick();
        end

        // Fixed priority: port 1 starves until port 0 lets go
        reset_all();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, c < 5, 1'b0, 32'h40, 0, 1'b1, 1'b0, 32'h80, 0);
            #1;
            chk($sformatf("fp%0d p0_gnt", c), {31'd0, b_p0_gnt}, {31'd0, c < 5});
            chk($sformatf("fp%0d p1_gnt", c), {31'd0, b_p1_gnt}, {31'd0, c == 5});
            tick();
        end

        // Random traffic against an in-order memory model, once per priority mode
        for (int sel = 0; sel < 2; sel++) begin
            reset_all();
            for (int i = 0; i < 1024; i++) mdl_mem[i] = preload(i);
            q.delete();
            last = 1'b1;
            erd0 = '0;
            erd1 = '0;
            pv_acc = 1'b0;
            pv_we = 1'b0;
            pv_addr = '0;
            pv_din = '0;
            for (int c = 0; c < 600; c++) begin
                rr = ($urandom_range(0, 39) != 0);
                r0 = ($urandom_range(0, 3) != 0);
                r1 = ($urandom_range(0, 3) != 0);
                w0 = $urandom_range(0, 1);
                w1 = $urandom_range(0, 1);
                a0 = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                a1 = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                d0 = $urandom;
                d1 = $urandom;
                drive(rr, r0, w0, a0, d0, r1, w1, a1, d1);
                #1;
                o_g0  = sel ? b_p0_gnt    : a_p0_gnt;
                o_g1  = sel ? b_p1_gnt    : a_p1_gnt;
                o_we  = sel ? b_mem_we    : a_mem_we;
                o_addr = sel ? b_mem_addr : a_mem_addr;
                o_din = sel ? b_mem_din   : a_mem_din;
                o_rv0 = sel ? b_p0_rvalid : a_p0_rvalid;
                o_rv1 = sel ? b_p1_rvalid : a_p1_rvalid;
                o_rd0 = sel ? b_p0_rdata  : a_p0_rdata;
                o_rd1 = sel ? b_p1_rdata  : a_p1_rdata;

                eg0 = 1'b0;
                eg1 = 1'b0;
                if (rr) begin
                    if (r0 && r1) begin
                        if (sel == 1 || last) eg0 = 1'b1;
                        else eg1 = 1'b1;
                    end else begin
                        eg0 = r0;
                        eg1 = r1;
                    end
                end
                chk($sformatf("rnd%0d.%0d gnt", sel, c), {30'd0, o_g1, o_g0}, {30'd0, eg1, eg0});
                chk($sformatf("rnd%0d.%0d mem_we", sel, c), {31'd0, o_we}, {31'd0, pv_acc && pv_we});
                if (pv_acc) chk($sformatf("rnd%0d.%0d mem_addr", sel, c), {22'd0, o_addr}, {22'd0, pv_addr});
                if (pv_acc && pv_we) chk($sformatf("rnd%0d.%0d mem_din", sel, c), o_din, pv_din);

                ev0 = 1'b0;
                ev1 = 1'b0;
                if (q.size() > 0 && q[0].due == c) begin
                    if (q[0].port == 0) begin ev0 = 1'b1; erd0 = q[0].data; end
                    else begin ev1 = 1'b1; erd1 = q[0].data; end
                    void'(q.pop_front());
                end
                chk($sformatf("rnd%0d.%0d rvalid", sel, c), {30'd0, o_rv1, o_rv0}, {30'd0, ev1, ev0});
                chk($sformatf("rnd%0d.%0d p0_rdata", sel, c), o_rd0, erd0);
                chk($sformatf("rnd%0d.%0d p1_rdata", sel, c), o_rd1, erd1);

                pv_acc = eg0 | eg1;
                pv_we = eg1 ? w1 : w0;
                pv_addr = eg1 ? a1[11:2] : a0[11:2];
                pv_din = eg1 ? d1 : d0;
                if (pv_acc) begin
                    last = eg1;
                    if (pv_we) mdl_mem[pv_addr] = pv_din;
                    else q.push_back('{port: (eg1 ? 1 : 0), data: mdl_mem[pv_addr], due: c + 2});
                end
                if (!rr) begin
                    q.delete();
                    last = 1'b1;
                    erd0 = '0;
                    erd1 = '0;
                    pv_acc = 1'b0;
                end
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
